// File: rtl/seq_alu.sv
// seq_alu: registered valid/ready ALU with flags, remainder and a multi-cycle restoring divider
module seq_alu #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] rem,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DIV  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, prem_q, prem_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] c_q, c_d, rem_q, rem_d;
    logic             zero_q, zero_d, carry_q, carry_d, dbz_q, dbz_d, ov_q, ov_d;

    logic             accept, start_div, ge;
    logic [WIDTH:0]   sum, diff, trial;
    logic [WIDTH-1:0] mul_lo, prem_next, quo_next;
    logic [WIDTH-1:0] alu_c, alu_rem;
    logic             alu_carry, alu_dbz;

    assign in_ready  = (state_q == IDLE) & (!ov_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign start_div = accept & (sel == 3'b100) & (b != '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign trial     = {prem_q, quo_q[WIDTH-1]};
    assign ge        = trial >= {1'b0, dvs_q};
    assign prem_next = ge ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    assign quo_next  = {quo_q[WIDTH-2:0], ge};

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        mul_lo    = a * b;
        alu_c     = a;
        alu_rem   = '0;
        alu_carry = 1'b0;
        alu_dbz   = 1'b0;
        case (sel)
            3'b001: begin alu_c = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
            3'b010: begin alu_c = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
            3'b011: alu_c = mul_lo;
            3'b100: begin alu_c = '1; alu_rem = a; alu_dbz = 1'b1; end
            3'b101: alu_c = a & b;
            3'b110: alu_c = a | b;
            3'b111: alu_c = a ^ b;
            default: alu_c = a;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        c_d     = c_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q & !out_ready;
        if (state_q == IDLE) begin
            if (start_div) begin
                state_d = DIV;
                cnt_d   = '0;
                quo_d   = a;
                prem_d  = '0;
                dvs_d   = b;
            end else if (accept) begin
                c_d     = alu_c;
                rem_d   = alu_rem;
                carry_d = alu_carry;
                dbz_d   = alu_dbz;
                zero_d  = alu_c == '0;
                ov_d    = 1'b1;
            end
        end else begin
            quo_d  = quo_next;
            prem_d = prem_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = IDLE;
                c_d     = quo_next;
                rem_d   = prem_next;
                carry_d = 1'b0;
                dbz_d   = 1'b0;
                zero_d  = quo_next == '0;
                ov_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    assign out_valid   = ov_q;
    assign c           = c_q;
    assign rem         = rem_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=20
module tb_seq_alu;
    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] c;
    logic [W-1:0] rem;
    logic         zero;
    logic         carry;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .rem(rem), .zero(zero), .carry(carry), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        sel = s; a = x; b = y; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero} !== 44'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", {out_valid, c, rem, zero, carry, div_by_zero}, 44'h0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        drive(3'b001, 20'hFFFFF, 20'h00001);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero} !== {1'b1, 20'h00000, 20'h00000, 3'b110}) begin
            errors++;
            $display("FAIL add_carry: got %h expected %h", {out_valid, c, rem, zero, carry, div_by_zero}, {1'b1, 20'h00000, 20'h00000, 3'b110});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_single_cycle: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(3'b010, 20'd3, 20'd5);
        tick();
        checks++;
        if ({out_valid, c, zero, carry, in_ready} !== {1'b1, 20'hFFFFE, 3'b011}) begin
            errors++;
            $display("FAIL sub_borrow: got %h expected %h", {out_valid, c, zero, carry, in_ready}, {1'b1, 20'hFFFFE, 3'b011});
        end
        drive(3'b011, 20'h00400, 20'h00400);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, c, rem, zero, carry} !== {1'b1, 20'h00000, 20'h00000, 2'b10}) begin
            errors++;
            $display("FAIL mul_truncate: got %h expected %h", {out_valid, c, rem, zero, carry}, {1'b1, 20'h00000, 20'h00000, 2'b10});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] q, input logic [W-1:0] r, input string nm);
        int busy_bad = 0;
        drive(3'b100, x, y);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) busy_bad++;
            if (i < W - 1) tick();
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s_busy: %0d cycles with out_valid/in_ready high, expected 0", nm, busy_bad);
        end
        tick();
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero, in_ready} !== {1'b1, q, r, q == '0, 3'b001}) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", nm, {out_valid, c, rem, zero, carry, div_by_zero, in_ready}, {1'b1, q, r, q == '0, 3'b001});
        end
    endtask

    task automatic test_div();
        run_div(20'd100, 20'd7, 20'd14, 20'd2, "div_100_7");
        run_div(20'hFFFFF, 20'd1, 20'hFFFFF, 20'd0, "div_max_1");
        tick();
    endtask

    task automatic test_div_by_zero();
        drive(3'b100, 20'h12345, 20'h00000);
        tick();
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero} !== {1'b1, 20'hFFFFF, 20'h12345, 3'b001}) begin
            errors++;
            $display("FAIL div_by_zero: got %h expected %h", {out_valid, c, rem, zero, carry, div_by_zero}, {1'b1, 20'hFFFFF, 20'h12345, 3'b001});
        end
        drive(3'b101, 20'hF0F0F, 20'h0FF00);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero} !== {1'b1, 20'h00F00, 20'h00000, 3'b000}) begin
            errors++;
            $display("FAIL and_after_dbz: got %h expected %h", {out_valid, c, rem, zero, carry, div_by_zero}, {1'b1, 20'h00F00, 20'h00000, 3'b000});
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'b110, 20'h0A0A0, 20'h05050);
        tick();
        drive(3'b111, 20'hFFFFF, 20'h0000F);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, c, zero, carry, div_by_zero, in_ready} !== {1'b1, 20'h0F0F0, 4'b0000}) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got %h expected %h", i, {out_valid, c, zero, carry, div_by_zero, in_ready}, {1'b1, 20'h0F0F0, 4'b0000});
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, c, zero} !== {1'b1, 20'hFFFF0, 1'b0}) begin
            errors++;
            $display("FAIL backpressure_queued: got %h expected %h", {out_valid, c, zero}, {1'b1, 20'hFFFF0, 1'b0});
        end
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_div();
        int stale = 0;
        drive(3'b100, 20'd1000, 20'd3);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, c, rem, zero, carry, div_by_zero, in_ready} !== {44'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {out_valid, c, rem, zero, carry, div_by_zero, in_ready}, {44'h0, 1'b1});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_no_stale: %0d bad cycles, expected 0", stale);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_div();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
